// File: rtl/io_port_ctrl.sv
// io_port_ctrl: processor I/O port with debounced switch capture and a hex/decimal
// seven-segment display driver that stalls the core through Busy.
module io_port_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 18,
  parameter int DIGITS          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  IO,
  input  logic                  Dec_Mode,
  input  logic                  Blank_Zeros,
  input  logic [DATA_WIDTH-1:0] Data_Out,
  input  logic [SW_WIDTH-1:0]   Raw_Input,
  input  logic                  Confirm,
  output logic [DATA_WIDTH-1:0] Data_In,
  output logic                  In_Valid,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] Data_Debug,
  output logic [7*DIGITS-1:0]   Display
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int NW = $clog2(DATA_WIDTH + 1);
  localparam logic [16*7-1:0] SEG_TAB = {
    7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, CONVERT} state_t;
  state_t state;
  logic en_q, pend, op_io, op_dec, op_blk, ovf, accept, nz;
  logic c_s1, c_s2, db, db_next;
  logic [CW-1:0] db_cnt;
  logic [SW_WIDTH-1:0] raw_s1, raw_s2;
  logic [DATA_WIDTH-1:0] op;
  logic [BW-1:0] bcd, adj, dig;
  logic [NW-1:0] n;
  logic [7*DIGITS-1:0] segs;
  assign accept = Enable && !en_q && state == IDLE && !pend;
  assign db_next = (c_s2 != db && db_cnt == CW'(DEBOUNCE_CYCLES - 1)) ? c_s2 : db;
  assign dig = (state == CONVERT) ? bcd : BW'(op);
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // Leading-zero blanking scans from the top digit down; digit 0 always shows.
  always_comb begin
    nz = 1'b0;
    segs = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz = nz | (dig[4*k +: 4] != 4'd0);
      segs[7*k +: 7] = (op_blk && !nz && k != 0) ? 7'h7f : SEG_TAB[7*dig[4*k +: 4] +: 7];
    end
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      c_s1 <= 1'b0;
      c_s2 <= 1'b0;
      raw_s1 <= '0;
      raw_s2 <= '0;
      db <= 1'b0;
      db_cnt <= '0;
    end else begin
      c_s1 <= Confirm;
      c_s2 <= c_s1;
      raw_s1 <= Raw_Input;
      raw_s2 <= raw_s1;
      db <= db_next;
      db_cnt <= (c_s2 == db || db_next != db) ? '0 : db_cnt + 1'b1;
    end
  // The request is latched into op_* first and acted on the following cycle.
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      en_q <= 1'b0;
      pend <= 1'b0;
      op_io <= 1'b0;
      op_dec <= 1'b0;
      op_blk <= 1'b0;
      op <= '0;
      bcd <= '0;
      n <= '0;
      ovf <= 1'b0;
      Data_In <= '0;
      In_Valid <= 1'b0;
      Busy <= 1'b0;
      Data_Debug <= '0;
      Display <= {DIGITS{7'h40}};
    end else begin
      en_q <= Enable;
      Data_Debug <= Data_Out;
      In_Valid <= 1'b0;
      pend <= accept;
      if (accept) begin
        op <= Data_Out;
        op_io <= IO;
        op_dec <= Dec_Mode;
        op_blk <= Blank_Zeros;
      end
      case (state)
        IDLE:
          if (pend) begin
            if (!op_io) begin
              state <= WAIT_PRESS;
              Busy <= 1'b1;
            end else if (op_dec) begin
              state <= CONVERT;
              Busy <= 1'b1;
              bcd <= '0;
              n <= '0;
              ovf <= 1'b0;
            end else
              Display <= segs;
          end
        WAIT_PRESS:
          if (db_next && !db) begin
            Data_In <= DATA_WIDTH'(raw_s2);
            state <= WAIT_RELEASE;
          end
        WAIT_RELEASE:
          if (!db_next && db) begin
            state <= IDLE;
            Busy <= 1'b0;
            In_Valid <= 1'b1;
          end
        CONVERT:
          if (n == NW'(DATA_WIDTH)) begin
            state <= IDLE;
            Busy <= 1'b0;
            Display <= ovf ? {DIGITS{7'h3f}} : segs;
          end else begin
            bcd <= {adj[BW-2:0], op[DATA_WIDTH-1]};
            ovf <= ovf | adj[BW-1];
            op <= op << 1;
            n <= n + 1'b1;
          end
      endcase
    end
endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Parametrised processor I/O port: captures switch input on a debounced confirm press and drives a bank of active-low seven-segment digits from a processor output word, in hexadecimal or unsigned decimal with optional leading-zero blanking. It sits between the datapath's I/O instruction decode and the board switches, button and displays. A single `Busy` line stalls the core while an input is pending or a decimal conversion runs.

## Interface
- `DATA_WIDTH`, 32, width of `Data_Out`, `Data_In` and `Data_Debug`.
- `SW_WIDTH`, 18, switch width. Must be less than or equal to `DATA_WIDTH`.
- `DIGITS`, 8, number of seven-segment digits driven.
- `DEBOUNCE_CYCLES`, 4, consecutive stable synchronised samples needed to accept a `Confirm` level change. Must be at least 1.
- `Clock`, in, 1, system clock. All state changes on the rising edge.
- `Reset`, in, 1, asynchronous, active-high.
- `Enable`, in, 1, I/O instruction active. The request is the rising edge of `Enable`.
- `IO`, in, 1, direction: 1 = output (write displays), 0 = input (read switches).
- `Dec_Mode`, in, 1, output format: 0 = hex, 1 = unsigned decimal. Sampled with the request.
- `Blank_Zeros`, in, 1, suppress leading zero digits. Sampled with the request.
- `Data_Out`, in, `DATA_WIDTH`, word to display.
- `Raw_Input`, in, `SW_WIDTH`, asynchronous switches.
- `Confirm`, in, 1, asynchronous push button, active-high.
- `Data_In`, out, `DATA_WIDTH`, captured switch value, zero-extended.
- `In_Valid`, out, 1, one-cycle pulse when an input transaction completes.
- `Busy`, out, 1, core stall request.
- `Data_Debug`, out, `DATA_WIDTH`, `Data_Out` registered every cycle.
- `Display`, out, `7*DIGITS`, segments, active-low. Digit *k* is on bits [7k+6:7k]; digit 0 is least significant.

## Operation
- **Input synchronisation**
  - `Confirm` and `Raw_Input` pass through 2-flop synchronisers.
  - The debounced `Confirm` changes only after `DEBOUNCE_CYCLES` consecutive equal synchronised samples.
- **Request detection**
  - `Enable` is registered; a request is `Enable & ~Enable_q`.
  - Requests are honoured only in `IDLE`. Requests arriving in any other state are dropped, not queued.
- **States:** `IDLE`, `WAIT_PRESS`, `WAIT_RELEASE`, `CONVERT`.
  - `IDLE` + request with `IO`=0 → `WAIT_PRESS`; `Busy`=1.
  - `WAIT_PRESS`, on debounced `Confirm` rising → `Data_In` ← {zeros, synchronised `Raw_Input`}, captured on that same cycle; go to `WAIT_RELEASE`.
  - `WAIT_RELEASE`, on debounced `Confirm` falling → `IDLE`; `Busy`=0; `In_Valid`=1 for one cycle.
  - If the button is already held when the request arrives, a release then a new press is required before capture.
  - `IDLE` + request with `IO`=1, `Dec_Mode`=0 → latch `Data_Out`; displays show hex nibbles on the next cycle; stay in `IDLE`; `Busy` stays 0.
  - `IDLE` + request with `IO`=1, `Dec_Mode`=1 → `CONVERT`; `Busy`=1.
- **Decimal conversion (`CONVERT`)**
  - Sequential double-dabble on a `4*DIGITS`-bit BCD register, one input bit per cycle, MSB first, `DATA_WIDTH` iterations.
  - Overflow flag sets if a 1 shifts out of the top BCD digit.
  - After the final iteration the displays load and the FSM returns to `IDLE`.
  - On overflow, every digit shows '-' (7'b011_1111).
- **Hex digits**
  - Nibble *k* goes to digit *k*.
  - Nibbles beyond `DATA_WIDTH` read as 0.
  - Digits beyond `DIGITS` are truncated silently.
- **Segment encoding (gfedcba, active-low)**
  - 0–9: 100_0000, 111_1001, 010_0100, 011_0000, 001_1001, 001_0010, 000_0010, 111_1000, 000_0000, 001_0000
  - A–F: 000_1000, 000_0011, 100_0110, 010_0001, 000_0110, 000_1110
  - Blank: 111_1111
- **Blanking**
  - When `Blank_Zeros`=1, zero digits above the most significant nonzero digit show blank.
  - Digit 0 is never blanked.
- **Output hold:** displays keep their last value until the next completed output operation.

## Timing
- **Reset values:**
  - every `Display` digit = 100_0000 ('0')
  - `Data_In` = 0, `Data_Debug` = 0
  - `Busy` = 0, `In_Valid` = 0
  - FSM = `IDLE`; synchronisers and debounce state cleared
- **Reset mid-operation** aborts any transaction and restores all outputs to reset values immediately.
- **Hex output:** request at edge N → `Display` updated at edge N+1.
- **Decimal output:**
  - `Busy` rises at edge N+1 and is high for `DATA_WIDTH`+1 cycles.
  - `Display` updates on the same edge `Busy` falls.
- **Input latency:** from `Confirm` rising to capture is 2 (sync) + `DEBOUNCE_CYCLES` cycles, and the same from release to `In_Valid`.
- **Input handshake:**
  - `Busy` rises on the edge after the request.
  - `Data_In` is stable from capture onward and valid when `In_Valid`=1.
  - `Busy` falls on the same edge `In_Valid` rises.
- **Glitches:** a `Confirm` glitch shorter than `DEBOUNCE_CYCLES` is ignored in every state.
- **`Data_Debug`** = `Data_Out` delayed one cycle, independent of the FSM.

## Test plan
- **Hex output:** `Data_Out`=0x1234ABCD, `IO`=1, `Dec_Mode`=0, `Enable` pulse → next cycle digits 7..0 = 1,2,3,4,A,b,C,d encodings; `Busy` never high.
- **Decimal with blanking:** `Data_Out`=1234, `Dec_Mode`=1, `Blank_Zeros`=1 → `Busy` high for 33 cycles; then digits 3..0 = 1,2,3,4 and digits 7..4 = 111_1111.
- **Decimal overflow:** `Data_Out`=0xFFFFFFFF, `Dec_Mode`=1, `DIGITS`=8 → all digits = 011_1111.
- **Input:**
  - `IO`=0 request, `Raw_Input`=18'h2A5F3, 2-cycle `Confirm` glitch → no capture.
  - Then a 10-cycle press with `Raw_Input` held at 18'h2A5F3, then release → `Data_In`=0x0002A5F3; single `In_Valid` pulse; `Busy` falls with it.
- **Dropped request:** second `Enable` rising edge during `WAIT_PRESS` → ignored; only one `In_Valid`.
- **Reset mid-transaction:** `Reset` asserted mid-`CONVERT` and mid-`WAIT_RELEASE` → `Busy`=0 and displays show '0' immediately (asynchronous); next request behaves normally.
